fpu_addsub_arbiter: RTL
=======================

# fpu_addsub_arbiter

Shares one fixed-latency FPU add/sub datapath between NREQ requesters. Round-robin arbitration grants at most one request per cycle. The block registers the winner's operands onto the datapath and tracks the requester ID through a LAT-deep tag pipe. It then returns the datapath result to the originating requester. The block sits between the requester ports and the add/sub datapath instance and owns issue, drain and flush sequencing.

## Interface
- WIDTH, 32, operand/result width (IEEE-754 single).
- NREQ, 4, number of requesters (2..8).
- LAT, 6, cycles from operands presented on fpu_a/fpu_b to valid fpu_r.
- CNT_W, 16, grant counter width (FPU_ARB_PERF_EN only).

- clk  in  1  clock, all logic on posedge.
- arst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid&ready.
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_op  in  NREQ  operation select per requester (0 add, 1 sub).
- hold  in  1  stop new grants and drain in-flight ops.
- flush  in  1  discard all in-flight ops.
- fpu_a, fpu_b  out  WIDTH  registered operands to datapath.
- fpu_op  out  1  registered operation select to datapath.
- fpu_r  in  WIDTH  datapath result.
- rsp_valid  out  NREQ  one-hot response strobe.
- rsp_data  out  WIDTH  result, valid when any rsp_valid bit is set.
- idle  out  1  no ops in flight and state IDLE.
- grant_cnt  out  NREQ*CNT_W  per-requester grant counts (FPU_ARB_PERF_EN only).

## Operation
- **Arbitration**
  - Round-robin pointer ptr, reset 0.
  - Grant goes to the first i with req_valid[i], searching from ptr upward and wrapping modulo NREQ.
  - On a grant to i, ptr becomes (i+1) mod NREQ.
  - req_ready is combinational from req_valid, ptr, state, hold and flush.
  - req_ready is all-zero when hold=1, flush=1, or state=DRAIN.
- **Issue**
  - On a grant edge, fpu_a/fpu_b/fpu_op load the winner's operands.
  - Otherwise they hold their value. No operand gating; values are don't-care while no tag is valid.
- **Tag pipe**
  - LAT entries of {valid, id[$clog2(NREQ)-1:0]}.
  - Stage 0 loads {grant, winner id} every cycle and shifts one stage per cycle.
  - The last stage drives rsp_valid (one-hot of id when valid) and rsp_data = fpu_r (combinational pass-through).
- **States**
  - IDLE: no valid tags. Moves to BUSY on a grant.
  - BUSY: tags in flight. Moves to DRAIN when hold=1. Moves to IDLE when no valid tags remain after the shift and there is no grant.
  - DRAIN: no grants. Moves to IDLE when all tags are invalid.
  - idle = (state==IDLE).
- **Flush**
  - All tag valid bits clear on the same edge. Responses for in-flight ops are never produced.
  - No grant in the flush cycle. State goes to IDLE. ptr is unchanged.
- **Boundary conditions**
  - Simultaneous flush and hold: flush wins; state is IDLE next cycle.
  - hold deasserted in DRAIN: stay in DRAIN until empty, then IDLE.
  - Responses carry no backpressure. Requesters must accept rsp_valid on any cycle.
  - Datapath results, including canonical NaN 32'h7FC00000, pass unmodified.

## Timing
- Reset values:
  - req_ready and rsp_valid are 0.
  - rsp_data follows fpu_r.
  - fpu_a, fpu_b and fpu_op are 0.
  - All tags are invalid and ptr is 0.
  - State is IDLE, so idle is 1.
  - grant_cnt is 0.
- Grant in cycle t: operands appear on fpu_* in t+1, and rsp_valid pulses for exactly one cycle in t+1+LAT.
- Throughput is one op per cycle. Up to LAT ops are in flight.
- Reset mid-operation clears everything asynchronously. No response appears after reset for pre-reset grants.

## Configuration
- FPU_ARB_PERF_EN defined: grant_cnt is present.
  - Counter i increments on each grant to requester i.
  - Counters saturate at 2^CNT_W-1.
  - Counters clear only on arst.
- Undefined: the grant_cnt port and the counters are absent. All other behaviour is identical.

## Test plan
- Single op: req_valid=4'b0001, a=3F800000, b=40000000, op=0 at t=0 -> req_ready=0001 at t0; fpu_a=3F800000 at t1; rsp_valid=0001 with rsp_data=40400000 at t7; idle=1 at t8.
- All four requesters valid continuously from t0 with ptr=0 -> grants 0,1,2,3,0 on t0..t4; responses in the same order on t7..t11.
- Requester 2 back-to-back for 10 cycles, others idle -> 10 consecutive grants and 10 consecutive rsp_valid=0100 pulses.
- hold=1 at t3 after grants t0..t2 -> no grants while hold=1; state DRAIN; responses at t7..t9; idle=1 at t10.
- flush at t3 after grants t0..t2 -> no rsp_valid ever for those grants; idle=1 at t4; a grant at t4 responds at t11.
- arst pulse at t4 with 4 ops in flight -> all outputs at reset values; zero responses afterwards. With FPU_ARB_PERF_EN, grant_cnt clears; a later grant to requester 1 reads 1.

Source files
------------

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin front end that shares one fixed-latency FP add/sub datapath between NREQ requesters.
// Optional per-requester grant counters are enabled with the FPU_ARB_PERF_EN macro.
module fpu_addsub_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int LAT   = 6,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  input  logic [NREQ-1:0]        req_op,
  input  logic                   hold,
  input  logic                   flush,
  output logic [WIDTH-1:0]       fpu_a,
  output logic [WIDTH-1:0]       fpu_b,
  output logic                   fpu_op,
  input  logic [WIDTH-1:0]       fpu_r,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
`ifdef FPU_ARB_PERF_EN
  output logic [NREQ*CNT_W-1:0]  grant_cnt,
`endif
  output logic                   idle
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      win_id_s, idx_s;
  logic [IDW:0]        sum_s;
  logic                win_found_s, grant_s, pending_s;
  logic [WIDTH-1:0]    fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d, sel_a_s, sel_b_s;
  logic                fpu_op_q, fpu_op_d, sel_op_s;
  logic [LAT-1:0]      tag_v_q, tag_v_d;
  logic [IDW-1:0]      tag_id_q [LAT];
  logic [IDW-1:0]      tag_id_d [LAT];
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;

  // Round-robin search from ptr upward, wrapping modulo NREQ.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    sum_s       = '0;
    idx_s       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_q} + (IDW+1)'(k);
      sum_s = (sum_s >= (IDW+1)'(NREQ)) ? (sum_s - (IDW+1)'(NREQ)) : sum_s;
      idx_s = sum_s[IDW-1:0];
      if (!win_found_s && req_valid[idx_s]) begin
        win_found_s = 1'b1;
        win_id_s    = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    grant_s   = win_found_s && !hold && !flush && (state_q != ST_DRAIN);
    req_ready = grant_s ? ({{(NREQ-1){1'b0}}, 1'b1} << win_id_s) : {NREQ{1'b0}};
  end

  // Operand mux for the current winner.
  always_comb begin
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id_s == IDW'(i)) begin
        sel_a_s  = req_a[i*WIDTH +: WIDTH];
        sel_b_s  = req_b[i*WIDTH +: WIDTH];
        sel_op_s = req_op[i];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // Next-state for pointer, issue registers, tag pipe, response strobe and FSM.
  always_comb begin
    if (grant_s) begin
      ptr_d    = (win_id_s == IDW'(NREQ-1)) ? {IDW{1'b0}} : (win_id_s + IDW'(1));
      fpu_a_d  = sel_a_s;
      fpu_b_d  = sel_b_s;
      fpu_op_d = sel_op_s;
    end else begin
      ptr_d    = ptr_q;
      fpu_a_d  = fpu_a_q;
      fpu_b_d  = fpu_b_q;
      fpu_op_d = fpu_op_q;
    end

    tag_v_d     = flush ? {LAT{1'b0}} : {tag_v_q[LAT-2:0], grant_s};
    tag_id_d[0] = win_id_s;
    for (int i = 1; i < LAT; i++) begin
      tag_id_d[i] = tag_id_q[i-1];
    end

    // The extra response register aligns the strobe with fpu_r at grant+1+LAT.
    if (tag_v_q[LAT-1] && !flush) begin
      rsp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << tag_id_q[LAT-1];
    end else begin
      rsp_valid_d = {NREQ{1'b0}};
    end
    pending_s = (|tag_v_d) || (|rsp_valid_d);

    case (state_q)
      ST_IDLE:  state_d = grant_s ? ST_BUSY : ST_IDLE;
      ST_BUSY: begin
        if (hold) begin
          state_d = ST_DRAIN;
        end else if (!pending_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DRAIN: state_d = pending_s ? ST_DRAIN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= 1'b0;
      tag_v_q     <= '0;
      rsp_valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      tag_v_q     <= tag_v_d;
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < LAT; i++) begin
        tag_id_q[i] <= tag_id_d[i];
      end
    end
  end

  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = fpu_r;
  assign idle      = (state_q == ST_IDLE);

`ifdef FPU_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  // Saturating grant counters, cleared only by arst.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s && (win_id_s == IDW'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule
